// File: rtl/bus_arbiter.sv
// Two-master arbiter for one strobe/ready memory bus with response timeout.
// Optional round-robin arbitration under contention: define ARB_ROUND_ROBIN_EN.
module bus_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_read,
  input  logic              m0_write,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_wait,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_read,
  input  logic              m1_write,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              bus_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  // Counter value in the last ACCESS cycle before a timeout abort.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t              state_r, state_s;
  logic [7:0]          cnt_r, cnt_s;
  logic                gnt_r, gnt_s;
  logic                last_grant_r, last_grant_s;
  logic                dir_wr_r, dir_wr_s;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
  logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_s;
  logic                mem_read_r, mem_read_s;
  logic                mem_write_r, mem_write_s;
  logic [DATA_W-1:0]   m0_rdata_r, m0_rdata_s;
  logic [DATA_W-1:0]   m1_rdata_r, m1_rdata_s;
  logic                m0_wait_r, m0_wait_s;
  logic                m1_wait_r, m1_wait_s;
  logic                bus_error_r, bus_error_s;
  logic                req0_s, req1_s, pick_s;
  logic                wr_s;
  logic [DATA_W-1:0]   resp_s;

  // Next-state and next-output computation for the arbitration FSM.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    gnt_s        = gnt_r;
    last_grant_s = last_grant_r;
    dir_wr_s     = dir_wr_r;
    mem_addr_s   = mem_addr_r;
    mem_wdata_s  = mem_wdata_r;
    mem_read_s   = mem_read_r;
    mem_write_s  = mem_write_r;
    m0_rdata_s   = m0_rdata_r;
    m1_rdata_s   = m1_rdata_r;
    m0_wait_s    = 1'b1;
    m1_wait_s    = 1'b1;
    bus_error_s  = bus_error_r;
    req0_s       = m0_read | m0_write;
    req1_s       = m1_read | m1_write;
`ifdef ARB_ROUND_ROBIN_EN
    pick_s       = (req0_s && req1_s) ? ~last_grant_r : ~req0_s;
`else
    pick_s       = ~req0_s;
`endif
    wr_s         = pick_s ? m1_write : m0_write;
    resp_s       = mem_ready ? mem_rdata : {DATA_W{1'b1}};

    case (state_r)
      IDLE: begin
        if (req0_s || req1_s) begin
          gnt_s        = pick_s;
          last_grant_s = pick_s;
          dir_wr_s     = wr_s;
          mem_addr_s   = pick_s ? m1_addr : m0_addr;
          mem_wdata_s  = pick_s ? m1_wdata : m0_wdata;
          mem_read_s   = ~wr_s;
          mem_write_s  = wr_s;
          cnt_s        = 8'd0;
          state_s      = ACCESS;
        end else begin
          state_s      = IDLE;
        end
      end
      ACCESS: begin
        // mem_ready wins over a timeout landing in the same cycle.
        if (mem_ready || (cnt_r == TIMEOUT_LAST)) begin
          mem_read_s  = 1'b0;
          mem_write_s = 1'b0;
          if (!dir_wr_r && gnt_r) begin
            m1_rdata_s = resp_s;
          end else if (!dir_wr_r) begin
            m0_rdata_s = resp_s;
          end else begin
            m0_rdata_s = m0_rdata_r;
          end
          if (!mem_ready) begin
            bus_error_s = 1'b1;
          end else begin
            bus_error_s = bus_error_r;
          end
          if (gnt_r) begin
            m1_wait_s = 1'b0;
          end else begin
            m0_wait_s = 1'b0;
          end
          state_s = ACK;
        end else begin
          cnt_s   = cnt_r + 8'd1;
          state_s = ACCESS;
        end
      end
      ACK: begin
        state_s = IDLE;
      end
      default: begin
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        state_s     = IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= 8'd0;
      gnt_r        <= 1'b0;
      last_grant_r <= 1'b1;
      dir_wr_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      m0_rdata_r   <= '0;
      m1_rdata_r   <= '0;
      m0_wait_r    <= 1'b1;
      m1_wait_r    <= 1'b1;
      bus_error_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      gnt_r        <= gnt_s;
      last_grant_r <= last_grant_s;
      dir_wr_r     <= dir_wr_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      mem_read_r   <= mem_read_s;
      mem_write_r  <= mem_write_s;
      m0_rdata_r   <= m0_rdata_s;
      m1_rdata_r   <= m1_rdata_s;
      m0_wait_r    <= m0_wait_s;
      m1_wait_r    <= m1_wait_s;
      bus_error_r  <= bus_error_s;
    end
  end

  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_read  = mem_read_r;
  assign mem_write = mem_write_r;
  assign m0_rdata  = m0_rdata_r;
  assign m1_rdata  = m1_rdata_r;
  assign m0_wait   = m0_wait_r;
  assign m1_wait   = m1_wait_r;
  assign bus_error = bus_error_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized self-checking bench for bus_arbiter against a transaction-level model.
module tb_bus_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] m0_addr, m1_addr, mem_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic          m0_read, m0_write, m0_wait, m1_read, m1_write, m1_wait;
  logic          mem_read, mem_write, mem_ready, bus_error;

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_read(m0_read), .m0_write(m0_write),
    .m0_rdata(m0_rdata), .m0_wait(m0_wait),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_read(m1_read), .m1_write(m1_write),
    .m1_rdata(m1_rdata), .m1_wait(m1_wait),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_error(bus_error)
  );

  int errors = 0;
  int checks = 0;

  // Pending request of each master plus the expected architectural state.
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wdata [2];
  logic          p_rd [2];
  logic          p_wr [2];
  bit            pend [2];
  logic [DW-1:0] exp_rdata [2];
  bit            exp_err;
  int            last_g;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    m0_addr  = p_addr[0];  m0_wdata = p_wdata[0];
    m0_read  = pend[0] & p_rd[0];  m0_write = pend[0] & p_wr[0];
    m1_addr  = p_addr[1];  m1_wdata = p_wdata[1];
    m1_read  = pend[1] & p_rd[1];  m1_write = pend[1] & p_wr[1];
  endtask

  task automatic issue(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic rd, input logic wr);
    pend[m] = 1'b1; p_addr[m] = a; p_wdata[m] = d; p_rd[m] = rd; p_wr[m] = wr;
    drive();
  endtask

  task automatic model_reset();
    pend[0] = 1'b0; pend[1] = 1'b0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    exp_err = 1'b0; last_g = 1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_strobes"}, {mem_read, mem_write}, 2'b00);
    check_eq({tag, "_waits"}, {m0_wait, m1_wait}, 2'b11);
    check_eq({tag, "_rdata0"}, m0_rdata, exp_rdata[0]);
    check_eq({tag, "_rdata1"}, m1_rdata, exp_rdata[1]);
  endtask

  // Called at a negedge in an IDLE cycle with requests already driven.
  // lat: ready pulse in strobe cycle lat (0 = never); drop: winner releases early.
  task automatic run_txn(input int lat, input logic [DW-1:0] sdata, input bit drop);
    int w, k, nexp;
    bit is_wr, tmo;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    if (!pend[0] && !pend[1]) begin
      @(negedge clk);
      check_quiet("idle");
      return;
    end
`ifdef ARB_ROUND_ROBIN_EN
    if (pend[0] && pend[1]) w = 1 - last_g;
    else w = pend[0] ? 0 : 1;
`else
    w = pend[0] ? 0 : 1;
`endif
    last_g = w;
    is_wr  = p_wr[w];
    ea     = p_addr[w];
    ed     = p_wdata[w];
    tmo    = !(lat >= 1 && lat <= TO);
    nexp   = tmo ? TO : lat;
    @(negedge clk);
    k = 1;
    while ((mem_read || mem_write) && k <= TO + 4) begin
      check_eq("dir", {mem_read, mem_write}, is_wr ? 2'b01 : 2'b10);
      check_eq("addr", mem_addr, ea);
      check_eq("wdata", mem_wdata, ed);
      check_eq("busy_waits", {m0_wait, m1_wait}, 2'b11);
      mem_ready = (k == lat);
      mem_rdata = (k == lat) ? sdata : DW'($urandom);
      if (drop && k == 1) begin
        pend[w] = 1'b0;
        drive();
      end
      @(negedge clk);
      k++;
    end
    check_eq("strobe_cycles", k - 1, nexp);
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = DW'($urandom);
    if (!is_wr) exp_rdata[w] = tmo ? {DW{1'b1}} : sdata;
    if (tmo) exp_err = 1'b1;
    check_eq("ack_waits", {m0_wait, m1_wait}, (w == 0) ? 2'b01 : 2'b10);
    check_eq("ack_strobes", {mem_read, mem_write}, 2'b00);
    check_eq("ack_rdata0", m0_rdata, exp_rdata[0]);
    check_eq("ack_rdata1", m1_rdata, exp_rdata[1]);
    check_eq("bus_error", bus_error, exp_err);
    pend[w] = 1'b0;
    drive();
    @(negedge clk);
    mem_ready = 1'b0;
    check_quiet("post_ack");
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    for (int m = 0; m < 2; m++) begin
      p_addr[m] = '0; p_wdata[m] = '0; p_rd[m] = 1'b0; p_wr[m] = 1'b0;
    end
    model_reset();
    drive();
    repeat (3) @(negedge clk);
    check_quiet("reset");
    check_eq("reset_err", bus_error, 1'b0);
    check_eq("reset_addr", mem_addr, 16'h0000);
    check_eq("reset_wdata", mem_wdata, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read with a zero-wait slave, then single write with 4-cycle slave.
    issue(0, 16'h1234, 8'h00, 1'b1, 1'b0);
    run_txn(1, 8'h5A, 1'b0);
    issue(1, 16'h0040, 8'hC3, 1'b0, 1'b1);
    run_txn(4, 8'h00, 1'b0);

    // Simultaneous readers, then both held requesting for four transactions.
    issue(0, 16'h1000, 8'h11, 1'b1, 1'b0);
    issue(1, 16'h2000, 8'h22, 1'b1, 1'b0);
    run_txn(2, 8'hA1, 1'b0);
    run_txn(3, 8'hA2, 1'b0);
    issue(0, 16'h1001, 8'h11, 1'b1, 1'b0);
    issue(1, 16'h2001, 8'h22, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_txn(1, 8'(8'hB0 + i), 1'b0);
      if (!pend[0]) issue(0, 16'(16'h1100 + i), 8'h33, 1'b1, 1'b0);
      else issue(1, 16'(16'h2100 + i), 8'h44, 1'b1, 1'b0);
    end
    run_txn(1, 8'hC0, 1'b0);
    run_txn(1, 8'hC1, 1'b0);

    // Boundaries: ready on the timeout cycle, then no ready at all.
    issue(0, 16'h0BEE, 8'h00, 1'b1, 1'b0);
    run_txn(TO, 8'h77, 1'b0);
    check_eq("no_err_at_limit", bus_error, 1'b0);
    issue(0, 16'h0DAD, 8'h00, 1'b1, 1'b0);
    run_txn(0, 8'h00, 1'b0);
    check_eq("err_sticky", bus_error, 1'b1);

    for (int r = 0; r < 150; r++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 1) == 1) begin
          int pat;
          pat = $urandom_range(1, 3);
          issue(m, AW'($urandom), DW'($urandom), pat[0], pat[1]);
        end
      end
      run_txn($urandom_range(0, TO + 2), DW'($urandom), $urandom_range(0, 3) == 0);
    end

    // Reset in the middle of an access abandons it.
    issue(1, 16'h4321, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_reset_strobe", mem_read, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    drive();
    rst_n = 1'b1;
    check_quiet("mid_reset");
    check_eq("mid_reset_err", bus_error, 1'b0);
    @(negedge clk);
    check_quiet("after_reset");
    issue(0, 16'h00AA, 8'h00, 1'b1, 1'b0);
    run_txn(2, 8'h3C, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
